// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter
//   Round-robin arbiter placing NrHosts requesters onto one downstream bus
//   that has a single outstanding transaction. A request that is not granted
//   right away is frozen (HOLD) until the downstream grants it or the host
//   withdraws. Responses are routed back to the host that owns the transaction.
//
//   Optional feature: define BUS_ARB_TIMEOUT_EN to compile in a response
//   timeout. After TimeoutCycles cycles in WAIT_RSP without a response, an
//   error response is returned to the owner and timeout_o pulses.
//
// Ports
//   clk_i, rst_i    clock, synchronous active-high reset
//   host_req_i      per-host request
//   host_gnt_o      per-host grant (one-hot or zero)
//   host_rvalid_o   per-host response valid
//   host_err_o      per-host response error
//   host_sel_o      index of the host currently driving the downstream bus
//   bus_req_o       downstream request
//   bus_gnt_i       downstream grant
//   bus_rvalid_i    downstream response valid
//   bus_err_i       downstream response error
//   unsolicited_o   sticky: a response arrived with no transaction outstanding
//   timeout_o       one-cycle pulse on response timeout
module bus_rr_arbiter #(
   parameter int unsigned NrHosts       = 2,
   parameter int unsigned TimeoutCycles = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [NrHosts-1:0]         host_req_i,
   output logic [NrHosts-1:0]         host_gnt_o,
   output logic [NrHosts-1:0]         host_rvalid_o,
   output logic [NrHosts-1:0]         host_err_o,
   output logic [$clog2(NrHosts)-1:0] host_sel_o,
   output logic                       bus_req_o,
   input  logic                       bus_gnt_i,
   input  logic                       bus_rvalid_i,
   input  logic                       bus_err_i,
   output logic                       unsolicited_o,
   output logic                       timeout_o
);

   localparam int unsigned SelW = $clog2(NrHosts);

   typedef enum logic [1:0] {
      IDLE,
      HOLD,
      WAIT_RSP
   } state_e;

   state_e            state_q, state_d;
   logic [SelW-1:0]   last_ptr_q, last_ptr_d;
   logic [SelW-1:0]   owner_q, owner_d;
   logic [SelW-1:0]   frozen_q, frozen_d;
   logic              unsol_q, unsol_d;

   logic [SelW-1:0]   arb_idx;
   logic              arb_valid;
   logic [SelW-1:0]   sel;
   logic              bus_req;
   logic              handshake;
   logic              rsp_hit;
   logic              timeout_hit;

   // Rotating priority search: first requester strictly after last_ptr_q.
   always_comb begin
      int unsigned     cand;
      logic [SelW-1:0] cand_idx;
      arb_idx   = '0;
      arb_valid = 1'b0;
      cand      = 0;
      cand_idx  = '0;
      for (int unsigned k = 1; k <= NrHosts; k++) begin
         cand     = (32'(last_ptr_q) + k) % NrHosts;
         cand_idx = cand[SelW-1:0];
         if (!arb_valid && host_req_i[cand_idx]) begin
            arb_idx   = cand_idx;
            arb_valid = 1'b1;
         end
      end
   end

`ifdef BUS_ARB_TIMEOUT_EN
   logic [7:0] cnt_q, cnt_d;

   assign timeout_hit = (state_q == WAIT_RSP) && !bus_rvalid_i &&
                        (cnt_q == 8'(TimeoutCycles - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (state_d == WAIT_RSP && state_q != WAIT_RSP) begin
         cnt_d = '0;
      end else if (state_q == WAIT_RSP && !bus_rvalid_i) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         last_ptr_q <= SelW'(NrHosts - 1);
         owner_q    <= '0;
         frozen_q   <= '0;
         unsol_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_ptr_q <= last_ptr_d;
         owner_q    <= owner_d;
         frozen_q   <= frozen_d;
         unsol_q    <= unsol_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      last_ptr_d = last_ptr_q;
      owner_d    = owner_q;
      frozen_d   = frozen_q;
      unsol_d    = unsol_q | (bus_rvalid_i && state_q != WAIT_RSP);
      unique case (state_q)
         IDLE: begin
            if (handshake) begin
               state_d = WAIT_RSP;
            end else if (arb_valid) begin
               state_d  = HOLD;
               frozen_d = arb_idx;
            end
         end
         HOLD: begin
            if (handshake) begin
               state_d = WAIT_RSP;
            end else if (!bus_req) begin
               state_d = IDLE;
            end
         end
         WAIT_RSP: begin
            if (rsp_hit || timeout_hit) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (handshake) begin
         last_ptr_d = sel;
         owner_d    = sel;
      end
   end

   // Output logic
   always_comb begin
      sel     = owner_q;
      bus_req = 1'b0;
      unique case (state_q)
         IDLE: begin
            sel     = arb_idx;
            bus_req = arb_valid;
         end
         HOLD: begin
            sel     = frozen_q;
            bus_req = host_req_i[frozen_q];
         end
         default: begin
            sel     = owner_q;
            bus_req = 1'b0;
         end
      endcase
      handshake = bus_req && bus_gnt_i && !rst_i;
      rsp_hit   = (state_q == WAIT_RSP) && bus_rvalid_i;

      host_gnt_o    = '0;
      host_rvalid_o = '0;
      host_err_o    = '0;
      if (handshake) begin
         host_gnt_o[sel] = 1'b1;
      end
      if (!rst_i && rsp_hit) begin
         host_rvalid_o[owner_q] = 1'b1;
         host_err_o[owner_q]    = bus_err_i;
      end else if (!rst_i && timeout_hit) begin
         host_rvalid_o[owner_q] = 1'b1;
         host_err_o[owner_q]    = 1'b1;
      end
   end

   assign host_sel_o    = sel;
   assign bus_req_o     = bus_req && !rst_i;
   assign timeout_o     = timeout_hit && !rst_i;
   assign unsolicited_o = unsol_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
module tb_bus_rr_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned TO = 4;
   localparam int unsigned SW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req;
   logic [N-1:0]  gnt_o, rvalid_o, err_o;
   logic [SW-1:0] sel;
   logic          bus_req, bus_gnt, bus_rvalid, bus_err, unsol, tmo;

   always #5 clk = ~clk;

   bus_rr_arbiter #(
      .NrHosts       (N),
      .TimeoutCycles (TO)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .host_req_i    (req),
      .host_gnt_o    (gnt_o),
      .host_rvalid_o (rvalid_o),
      .host_err_o    (err_o),
      .host_sel_o    (sel),
      .bus_req_o     (bus_req),
      .bus_gnt_i     (bus_gnt),
      .bus_rvalid_i  (bus_rvalid),
      .bus_err_i     (bus_err),
      .unsolicited_o (unsol),
      .timeout_o     (tmo)
   );

   typedef struct {
      int   cyc;
      int   host;
      logic err;
      logic to;
   } ev_t;

   ev_t req_q[$];
   ev_t gnt_q[$];
   ev_t rsp_q[$];

   // Transaction-level reference: 0 = free, 1 = waiting for downstream grant
   // on a frozen host, 2 = transaction outstanding.
   int m_phase  = 0;
   int m_last   = N - 1;
   int m_owner  = 0;
   int m_frozen = 0;
   int m_wait   = 0;
   bit m_unsol  = 1'b0;
   bit exp_unsol_now = 1'b0;
   int cyc = 0;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   function automatic int pick(input logic [N-1:0] r, input int last);
      for (int k = 1; k <= N; k++) begin
         int h;
         h = (last + k) % N;
         if (r[h]) return h;
      end
      return -1;
   endfunction

   function automatic ev_t mk(input int h, input logic e, input logic t);
      ev_t ev;
      ev.cyc  = cyc;
      ev.host = h;
      ev.err  = e;
      ev.to   = t;
      return ev;
   endfunction

   task automatic model_grant(input int h);
      gnt_q.push_back(mk(h, 1'b0, 1'b0));
      m_last  = h;
      m_owner = h;
      m_phase = 2;
      m_wait  = 0;
   endtask

   task automatic step(input logic [N-1:0] r, input logic g, input logic rv,
                       input logic e, input logic rs);
      int h;
      @(negedge clk);
      req = r; bus_gnt = g; bus_rvalid = rv; bus_err = e; rst = rs;
      cyc++;
      exp_unsol_now = m_unsol;
      if (rs) begin
         m_phase = 0; m_last = N - 1; m_owner = 0; m_wait = 0; m_unsol = 1'b0;
      end else begin
         case (m_phase)
            0: begin
               h = pick(r, m_last);
               if (h >= 0) begin
                  req_q.push_back(mk(h, 1'b0, 1'b0));
                  if (g) model_grant(h);
                  else begin
                     m_phase  = 1;
                     m_frozen = h;
                  end
               end
               if (rv) m_unsol = 1'b1;
            end
            1: begin
               if (r[m_frozen]) begin
                  req_q.push_back(mk(m_frozen, 1'b0, 1'b0));
                  if (g) model_grant(m_frozen);
               end else begin
                  m_phase = 0;
               end
               if (rv) m_unsol = 1'b1;
            end
            default: begin
               if (rv) begin
                  rsp_q.push_back(mk(m_owner, e, 1'b0));
                  m_phase = 0;
               end else begin
`ifdef BUS_ARB_TIMEOUT_EN
                  if (m_wait == TO - 1) begin
                     rsp_q.push_back(mk(m_owner, 1'b1, 1'b1));
                     m_phase = 0;
                  end else begin
                     m_wait++;
                  end
`else
                  m_wait++;
`endif
               end
            end
         endcase
      end
   endtask

   // Monitor: samples between active edges and consumes expected events.
   always @(negedge clk) begin
      #2;
      if (rst === 1'b1) begin
         chk("reset_outputs_zero", 32'({bus_req, gnt_o, rvalid_o, err_o, tmo}), 32'd0);
      end else if (rst === 1'b0) begin
         bit   e;
         ev_t  ev;
         logic [N-1:0] oh;

         e = (req_q.size() > 0) && (req_q[0].cyc == cyc);
         chk("bus_req_present", 32'(bus_req), 32'(e));
         if (e) begin
            ev = req_q.pop_front();
            if (bus_req) chk("host_sel", 32'(sel), 32'(ev.host));
         end

         e = (gnt_q.size() > 0) && (gnt_q[0].cyc == cyc);
         chk("grant_present", 32'(|gnt_o), 32'(e));
         if (e) begin
            ev = gnt_q.pop_front();
            oh = '0;
            oh[ev.host] = 1'b1;
            if (|gnt_o) chk("grant_vector", 32'(gnt_o), 32'(oh));
         end

         e = (rsp_q.size() > 0) && (rsp_q[0].cyc == cyc);
         chk("rsp_present", 32'(|rvalid_o), 32'(e));
         if (e) begin
            ev = rsp_q.pop_front();
            oh = '0;
            oh[ev.host] = 1'b1;
            if (|rvalid_o)
               chk("rsp_vector", 32'({rvalid_o, err_o, tmo}),
                   32'({oh, (ev.err ? oh : {N{1'b0}}), ev.to}));
         end else begin
            chk("no_err_no_timeout", 32'({err_o, tmo}), 32'd0);
         end

         chk("unsolicited", 32'(unsol), 32'(exp_unsol_now));
      end
   end

   initial begin
      req = '0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0; rst = 1'b1;

      // Reset, then two-host alternation with response one cycle after grant.
      repeat (3) step(4'b0000, 0, 0, 0, 1);
      step(4'b0000, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(4'b0011, 1, 0, 0, 0);
         step(4'b0011, 1, 1, i[0], 0);
      end

      // Rotation with last_ptr=1 and requests 1010: 3, 1, 3.
      step(4'b0000, 0, 0, 0, 1);
      step(4'b0010, 1, 0, 0, 0);
      step(4'b0000, 0, 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(4'b1010, 1, 0, 0, 0);
         step(4'b1010, 0, 1, 1, 0);
      end

      // Frozen selection while downstream withholds grant.
      step(4'b0000, 0, 0, 0, 1);
      step(4'b0001, 0, 0, 0, 0);
      step(4'b0011, 0, 0, 0, 0);
      step(4'b0011, 0, 0, 0, 0);
      step(4'b0011, 1, 0, 0, 0);
      step(4'b0000, 0, 1, 0, 0);
      // Withdrawal while held leaves rotation where it was.
      step(4'b0100, 0, 0, 0, 0);
      step(4'b0000, 0, 0, 0, 0);
      step(4'b1111, 1, 0, 0, 0);
      step(4'b0000, 0, 1, 0, 0);

      // Stray response while idle sets the sticky flag until reset.
      step(4'b0000, 0, 1, 0, 0);
      repeat (3) step(4'b0000, 0, 0, 0, 0);
      step(4'b0000, 0, 0, 0, 1);
      step(4'b0000, 0, 0, 0, 0);

      // No response: timeout (when built in), then immediate re-grant.
      step(4'b0100, 1, 0, 0, 0);
      repeat (5) step(4'b0100, 1, 0, 0, 0);
      step(4'b0000, 0, 1, 0, 0);
      step(4'b0000, 0, 0, 0, 0);

      // Reset during an outstanding transaction; late response is unsolicited.
      step(4'b1000, 1, 0, 0, 0);
      step(4'b0000, 0, 0, 0, 1);
      step(4'b0000, 0, 1, 0, 0);
      step(4'b1111, 1, 0, 0, 0);
      step(4'b0000, 0, 1, 0, 0);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         logic [N-1:0] r;
         logic g, rv, e, rs;
         r  = N'($urandom_range(0, 15));
         g  = ($urandom_range(0, 1) == 1);
         rv = (m_phase == 2) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 24) == 0);
         e  = ($urandom_range(0, 1) == 1);
         rs = ($urandom_range(0, 59) == 0);
         step(r, g, rv, e, rs);
      end

      @(negedge clk);
      rst = 1'b1;
      #3;
      chk("req_queue_drained", 32'(req_q.size()), 32'd0);
      chk("gnt_queue_drained", 32'(gnt_q.size()), 32'd0);
      chk("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bus_rr_arbiter.md
BUS_RR_ARBITER -- requirements
Module: bus_rr_arbiter

Interface
REQ-001 SHALL have parameter NrHosts, default 2, number of requesting hosts (legal range 2..8).
REQ-002 SHALL have parameter TimeoutCycles, default 16, response-timeout limit in cycles (legal range 2..255).
REQ-003 SHALL have port clk_i, input, 1 bit, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port host_req_i, input, NrHosts bits, per-host request.
REQ-006 SHALL have port host_gnt_o, output, NrHosts bits, per-host grant (one-hot or zero).
REQ-007 SHALL have port host_rvalid_o, output, NrHosts bits, per-host response valid.
REQ-008 SHALL have port host_err_o, output, NrHosts bits, per-host response error.
REQ-009 SHALL have port host_sel_o, output, clog2(NrHosts) bits, index of the host currently driving the downstream bus.
REQ-010 SHALL have port bus_req_o, output, 1 bit, downstream request.
REQ-011 SHALL have port bus_gnt_i, input, 1 bit, downstream grant.
REQ-012 SHALL have port bus_rvalid_i, input, 1 bit, downstream response valid.
REQ-013 SHALL have port bus_err_i, input, 1 bit, downstream response error.
REQ-014 SHALL have port unsolicited_o, output, 1 bit, sticky flag for a response received with no transaction outstanding.
REQ-015 SHALL have port timeout_o, output, 1 bit, one-cycle pulse on response timeout.

Function
REQ-016 SHALL implement an FSM with states IDLE, HOLD and WAIT_RSP, with at most one transaction outstanding.
REQ-017 In IDLE with any host_req_i bit set: select the first requesting host searching upward from (last_ptr+1) mod NrHosts; bus_req_o=1 and host_sel_o=selection in the same cycle.
REQ-018 host_gnt_o[host_sel_o] SHALL equal bus_req_o AND bus_gnt_i combinationally; all other grant bits 0.
REQ-019 Handshake (bus_req_o and bus_gnt_i high): last_ptr<=host_sel_o, owner<=host_sel_o, next state WAIT_RSP.
REQ-020 IDLE with a request but bus_gnt_i low: next state HOLD; the selection is registered and frozen.
REQ-021 HOLD: bus_req_o=1 and host_sel_o=frozen selection until handshake (then WAIT_RSP); no re-arbitration in HOLD.
REQ-022 HOLD with frozen host's request low: bus_req_o=0, next state IDLE, last_ptr unchanged.
REQ-023 WAIT_RSP: bus_req_o=0 and host_gnt_o=0.
REQ-024 WAIT_RSP with bus_rvalid_i=1: host_rvalid_o[owner]=1 and host_err_o[owner]=bus_err_i in the same cycle; next state IDLE.
REQ-025 Minimum grant-to-grant spacing SHALL be 2 cycles (grant, response, grant).
REQ-026 bus_rvalid_i in IDLE or HOLD: no host_rvalid_o; set unsolicited_o, which stays set until reset.
REQ-027 host_rvalid_o and host_err_o SHALL be zero except as stated in REQ-024 and REQ-032.

Reset
REQ-028 rst_i high at a clock edge: state<=IDLE, last_ptr<=NrHosts-1 (host 0 wins first), owner<=0, unsolicited_o<=0, timeout counter<=0.
REQ-029 Reset asserted in HOLD or WAIT_RSP SHALL abandon the transaction with no response delivered; a late bus_rvalid_i sets unsolicited_o.
REQ-030 While rst_i is high, bus_req_o, host_gnt_o, host_rvalid_o, host_err_o and timeout_o SHALL be 0.

Configuration
REQ-031 Macro BUS_ARB_TIMEOUT_EN SHALL compile in the response-timeout feature.
REQ-032 With BUS_ARB_TIMEOUT_EN defined: an 8-bit counter clears on entry to WAIT_RSP and increments each WAIT_RSP cycle without bus_rvalid_i; at count==TimeoutCycles-1 without response: host_rvalid_o[owner]=1, host_err_o[owner]=1, timeout_o=1 for one cycle, next state IDLE.
REQ-033 With BUS_ARB_TIMEOUT_EN defined, bus_rvalid_i in the timeout cycle SHALL take priority: normal response, no timeout_o.
REQ-034 Without BUS_ARB_TIMEOUT_EN: WAIT_RSP waits indefinitely, timeout_o is tied 0, and no counter is present.

Verification
REQ-035 After reset, host_req_i=2'b11, bus_gnt_i=1, bus_rvalid_i one cycle after each grant -> grants alternate 0,1,0,1 with host_rvalid_o following each grant by 1 cycle.
REQ-036 NrHosts=4, host_req_i=4'b1010 with last_ptr=1 -> host 3 granted; then host 1; then host 3.
REQ-037 host_req_i=2'b01 with bus_gnt_i low for 3 cycles -> HOLD with host_sel_o=0 throughout; host 1 raising its request meanwhile is not selected; handshake in cycle 4.
REQ-038 bus_rvalid_i=1 while IDLE -> no host_rvalid_o, unsolicited_o=1 until rst_i.
REQ-039 BUS_ARB_TIMEOUT_EN, TimeoutCycles=4, no response -> on the 4th WAIT_RSP cycle host_rvalid_o[owner]=1, host_err_o[owner]=1, timeout_o=1; next request granted the following cycle.
REQ-040 rst_i asserted in WAIT_RSP -> IDLE next cycle with all outputs 0; following grant goes to host 0.
